// File: rtl/serial_word_feeder_pkg.sv
// ----------------------------------------------------------------------------
// serial_feeder_pkg
//
// Shared definitions for the serial word feeder:
//   state_t    - feeder FSM states (IDLE, SHIFT, DONE, GAP)
//   DIR_LEFT   - direction code: shift left, MSB sent first
//   DIR_RIGHT  - direction code: shift right, LSB sent first
//   GAP_CNT_W  - width of the inter-word gap counter
// ----------------------------------------------------------------------------
package serial_feeder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2,
    GAP   = 2'd3
  } state_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  localparam int GAP_CNT_W = 8;

endpackage

// File: rtl/serial_word_feeder_if.sv
// ----------------------------------------------------------------------------
// serial_word_feeder_if
//
// Upstream word handshake into the serial word feeder.
//
// Handshake: a word transfers on a rising clock edge where in_valid and
// in_ready are both high. in_data and in_dir are only meaningful in that
// cycle. The feeder never withdraws in_ready without a transfer or reset,
// and in_valid may stay high across several words.
//
// Signals:
//   in_valid  upstream word valid            (master -> slave)
//   in_ready  feeder can accept a word       (slave  -> master)
//   in_data   word to serialize, WIDTH bits  (master -> slave)
//   in_dir    0 = shift left, 1 = shift right (master -> slave)
//
// Modports:
//   master - upstream word source
//   slave  - the feeder
// ----------------------------------------------------------------------------
interface serial_word_feeder_if #(
  parameter int WIDTH = 4
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_dir;

  modport master (
    output in_valid,
    output in_data,
    output in_dir,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_dir,
    output in_ready
  );

endinterface

// File: rtl/serial_word_feeder_bit_counter.sv
// ----------------------------------------------------------------------------
// feeder_bit_counter
//
// Loadable down-counter with zero and last flags. Loading wins over
// decrementing. The counter saturates at zero instead of wrapping.
//
// Ports:
//   clk       clock, rising edge
//   rst       synchronous active-high reset (count -> 0)
//   load      load load_val on the next edge
//   load_val  value to load
//   dec       decrement on the next edge (ignored at zero)
//   zero      count is 0
//   last      count is 1, i.e. the next decrement reaches zero
// ----------------------------------------------------------------------------
module feeder_bit_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero,
  output logic         last
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);
  assign last = (count_q == W'(1));

endmodule

// File: rtl/serial_word_feeder.sv
// ----------------------------------------------------------------------------
// serial_word_feeder
//
// Upstream driver for a WIDTH-bit bidirectional shift register. A word
// accepted over the up interface is serialized one bit per cycle onto
// serial_out, with exactly one of shift_left / shift_right strobing each
// bit in. After WIDTH strobes the downstream register holds the word and
// word_done pulses for one cycle.
//
// Parameters:
//   WIDTH     word width (>= 2), equal to the downstream register width
//   IDLE_GAP  idle cycles after each word before accepting the next (0..255)
//
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   up           word handshake (slave modport): in_valid/in_ready/in_data/in_dir
//   serial_out   downstream serial_in
//   shift_left   downstream shift_left strobe (dir 0, MSB first)
//   shift_right  downstream shift_right strobe (dir 1, LSB first)
//   word_done    one-cycle pulse: downstream now holds the word
//   busy         FSM is not in IDLE
//   stall        (only with SERIAL_FEEDER_STALL_EN) freeze the bit stream
//   dbg_state    current FSM state, for observation
//
// Build option:
//   SERIAL_FEEDER_STALL_EN - adds the stall input. While stall is high in
//   SHIFT, strobes and serial_out are 0 and the buffer/counter hold.
//   Without it the feeder behaves as if stall were tied low.
// ----------------------------------------------------------------------------
module serial_word_feeder
  import serial_feeder_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int IDLE_GAP = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_word_feeder_if.slave  up,
  output logic                 serial_out,
  output logic                 shift_left,
  output logic                 shift_right,
  output logic                 word_done,
  output logic                 busy,
`ifdef SERIAL_FEEDER_STALL_EN
  input  logic                 stall,
`endif
  output state_t               dbg_state
);

  localparam int BIT_CNT_W = $clog2(WIDTH + 1);

  // --------------------------------------------------------------------------
  // Optional stall
  // --------------------------------------------------------------------------
  logic stall_w;

`ifdef SERIAL_FEEDER_STALL_EN
  assign stall_w = stall;
`else
  assign stall_w = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] buf_q;
  logic [WIDTH-1:0] buf_d;
  logic             dir_q;
  logic             dir_d;

  logic             accept;
  logic             advance;
  logic             cur_bit;
  logic             ready_w;

  logic             bit_load;
  logic             bit_zero;
  logic             bit_last;
  logic             gap_load;
  logic             gap_dec;
  logic             gap_zero;
  logic             gap_last;

  // With no gap configured, the DONE cycle also accepts the next word so
  // back-to-back words run at one per WIDTH+1 cycles. With a gap, the DONE
  // cycle is followed by GAP and only IDLE accepts.
  assign ready_w = (state_q == IDLE) ||
                   ((IDLE_GAP == 0) && (state_q == DONE));

  assign accept  = ready_w && up.in_valid;
  assign advance = (state_q == SHIFT) && !stall_w;

  // Current bit: the buffer always shifts toward the end being sent, so the
  // outgoing bit sits at a fixed position per direction.
  assign cur_bit = (dir_q == DIR_LEFT) ? buf_q[WIDTH-1] : buf_q[0];

  // --------------------------------------------------------------------------
  // Counters
  // --------------------------------------------------------------------------
  feeder_bit_counter #(
    .W (BIT_CNT_W)
  ) u_bit_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (bit_load),
    .load_val (BIT_CNT_W'(WIDTH)),
    .dec      (advance),
    .zero     (bit_zero),
    .last     (bit_last)
  );

  assign gap_dec = (state_q == GAP);

  feeder_bit_counter #(
    .W (GAP_CNT_W)
  ) u_gap_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (gap_load),
    .load_val (GAP_CNT_W'(IDLE_GAP)),
    .dec      (gap_dec),
    .zero     (gap_zero),
    .last     (gap_last)
  );

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    dir_d    = dir_q;
    bit_load = 1'b0;
    gap_load = 1'b0;

    case (state_q)
      IDLE: begin
        state_d = IDLE;
      end

      SHIFT: begin
        if (advance) begin
          if (dir_q == DIR_LEFT) begin
            buf_d = buf_q << 1;
          end else begin
            buf_d = buf_q >> 1;
          end
          // bit_last: this cycle emits the final bit. bit_zero cannot occur
          // in SHIFT but is treated as finished rather than stalling forever.
          if (bit_last || bit_zero) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        if (IDLE_GAP > 0) begin
          state_d  = GAP;
          gap_load = 1'b1;
        end else begin
          state_d  = IDLE;
        end
      end

      GAP: begin
        if (gap_last || gap_zero) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // A handshake overrides whatever IDLE/DONE chose.
    if (accept) begin
      state_d  = SHIFT;
      buf_d    = up.in_data;
      dir_d    = up.in_dir;
      bit_load = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      buf_q   <= '0;
      dir_q   <= DIR_LEFT;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      dir_q   <= dir_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs, decoded from registered state
  // --------------------------------------------------------------------------
  assign up.in_ready  = ready_w;
  assign busy         = (state_q != IDLE);
  assign word_done    = (state_q == DONE);
  assign serial_out   = advance && cur_bit;
  assign shift_left   = advance && (dir_q == DIR_LEFT);
  assign shift_right  = advance && (dir_q == DIR_RIGHT);
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_serial_word_feeder.sv
`timescale 1ns/1ps
module tb_serial_word_feeder;
  import serial_feeder_pkg::*;

  localparam int W = 4;

  // --------------------------------------------------------------------------
  // Clock / reset
  // --------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // --------------------------------------------------------------------------
  // DUTs: dut0 with IDLE_GAP=0, dut2 with IDLE_GAP=2
  // --------------------------------------------------------------------------
  serial_word_feeder_if #(.WIDTH(W)) if0 ();
  serial_word_feeder_if #(.WIDTH(W)) if2 ();

  logic   so0, sl0, sr0, wd0, busy0;
  logic   so2, sl2, sr2, wd2, busy2;
  state_t st0, st2;
  logic   stall0 = 1'b0;

  serial_word_feeder #(.WIDTH(W), .IDLE_GAP(0)) dut0 (
    .clk         (clk),
    .rst         (rst),
    .up          (if0),
    .serial_out  (so0),
    .shift_left  (sl0),
    .shift_right (sr0),
    .word_done   (wd0),
    .busy        (busy0),
`ifdef SERIAL_FEEDER_STALL_EN
    .stall       (stall0),
`endif
    .dbg_state   (st0)
  );

  serial_word_feeder #(.WIDTH(W), .IDLE_GAP(2)) dut2 (
    .clk         (clk),
    .rst         (rst),
    .up          (if2),
    .serial_out  (so2),
    .shift_left  (sl2),
    .shift_right (sr2),
    .word_done   (wd2),
    .busy        (busy2),
`ifdef SERIAL_FEEDER_STALL_EN
    .stall       (1'b0),
`endif
    .dbg_state   (st2)
  );

  // Downstream 4-bit bidirectional shift registers
  logic [W-1:0] ds0 = '0;
  logic [W-1:0] ds2 = '0;
  always @(posedge clk) begin
    if (sl0)      ds0 <= {ds0[W-2:0], so0};
    else if (sr0) ds0 <= {so0, ds0[W-1:1]};
    if (sl2)      ds2 <= {ds2[W-2:0], so2};
    else if (sr2) ds2 <= {so2, ds2[W-1:1]};
  end

  // --------------------------------------------------------------------------
  // Scoreboard
  // --------------------------------------------------------------------------
  typedef struct {
    logic [W-1:0] word;  // value downstream must hold at word_done
    logic         dir;   // expected strobe direction
    logic [W-1:0] seq;   // serial_out bits, first bit in the MSB
    int           lat;   // cycles from handshake to word_done
  } exp_t;

  exp_t exp0_q[$];
  exp_t exp2_q[$];

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // --------------------------------------------------------------------------
  // Monitor for dut0
  // --------------------------------------------------------------------------
  int           hs0_cyc = 0;
  int           nb0     = 0;
  logic [W-1:0] bits0   = '0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      nb0   = 0;
      bits0 = '0;
    end else begin
      if (stall0) check("stall_quiet", {29'd0, sl0, sr0, so0}, 32'd0);
      if (sl0 || sr0) begin
        if (exp0_q.size() > 0)
          check("strobe_dir", {30'd0, sl0, sr0}, exp0_q[0].dir ? 32'd1 : 32'd2);
        bits0 = {bits0[W-2:0], so0};
        nb0++;
      end else begin
        check("quiet_serial", {31'd0, so0}, 32'd0);
      end
      if (wd0) begin
        if (exp0_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp0_q.pop_front();
          check("latency",   cyc - hs0_cyc, e.lat);
          check("ds_word",   {28'd0, ds0}, {28'd0, e.word});
          check("bit_order", {28'd0, bits0}, {28'd0, e.seq});
          check("bit_count", nb0, W);
          check("ready_at_done", {31'd0, if0.in_ready}, 32'd1);
        end
      end
      // Handshake handled after word_done so a back-to-back word does not
      // clear the record of the word completing in this same cycle.
      if (if0.in_valid && if0.in_ready) begin
        hs0_cyc = cyc;
        nb0     = 0;
        bits0   = '0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Monitor for dut2
  // --------------------------------------------------------------------------
  int           hs2_cyc = 0;
  logic [W-1:0] bits2   = '0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (sl2 || sr2) bits2 = {bits2[W-2:0], so2};
      if (wd2) begin
        if (exp2_q.size() == 0) begin
          check("unexpected_done2", 32'd1, 32'd0);
        end else begin
          e = exp2_q.pop_front();
          check("latency2",   cyc - hs2_cyc, e.lat);
          check("ds_word2",   {28'd0, ds2}, {28'd0, e.word});
          check("bit_order2", {28'd0, bits2}, {28'd0, e.seq});
          check("ready_low_at_done2", {31'd0, if2.in_ready}, 32'd0);
        end
      end
      if (if2.in_valid && if2.in_ready) begin
        hs2_cyc = cyc;
        bits2   = '0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Driver tasks (called at posedge+1)
  // --------------------------------------------------------------------------
  task automatic send0(input logic [W-1:0] d, input logic dr, input exp_t e,
                       input logic push, output int hc);
    int t;
    t = 0;
    if0.in_valid = 1'b1;
    if0.in_data  = d;
    if0.in_dir   = dr;
    @(negedge clk);
    while (!if0.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("hs_timeout", (t < 50) ? 32'd1 : 32'd0, 32'd1);
    hc = cyc;
    if (push) exp0_q.push_back(e);
    @(posedge clk);
    #1;
    if0.in_valid = 1'b0;
  endtask

  task automatic wait_idle0();
    for (int k = 0; k < 60 && exp0_q.size() > 0; k++) @(negedge clk);
    check("drain0", exp0_q.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    int   c1, c2, h1, h2;
    exp_t e;

    if0.in_valid = 1'b0; if0.in_data = '0; if0.in_dir = 1'b0;
    if2.in_valid = 1'b0; if2.in_data = '0; if2.in_dir = 1'b0;

    // Reset, then idle with in_valid low: {busy,ready,sl,sr,so,wd} = 010000
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("idle_outputs", {26'd0, busy0, if0.in_ready, sl0, sr0, so0, wd0}, 32'h10);
    end
    @(posedge clk); #1;

    // 1011 shift left: serial 1,0,1,1
    e = '{word: 4'b1011, dir: 1'b0, seq: 4'b1011, lat: 5};
    send0(4'b1011, 1'b0, e, 1'b1, c1);
    wait_idle0();

    // 1011 shift right: serial 1,1,0,1
    e = '{word: 4'b1011, dir: 1'b1, seq: 4'b1101, lat: 5};
    send0(4'b1011, 1'b1, e, 1'b1, c1);
    wait_idle0();

    // Back-to-back with in_valid held: second handshake 5 cycles later;
    // the second word's data sits on in_data during the first word's SHIFT.
    e = '{word: 4'b1000, dir: 1'b1, seq: 4'b0001, lat: 5};
    send0(4'b1000, 1'b1, e, 1'b1, c1);
    e = '{word: 4'b0110, dir: 1'b0, seq: 4'b0110, lat: 5};
    send0(4'b0110, 1'b0, e, 1'b1, c2);
    check("b2b_spacing", c2 - c1, 32'd5);
    wait_idle0();

    // Reset in the 2nd SHIFT cycle abandons the word
    send0(4'hC, 1'b0, e, 1'b0, c1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("after_rst", {26'd0, busy0, if0.in_ready, sl0, sr0, so0, wd0}, 32'h10);
    @(posedge clk); #1;
    e = '{word: 4'h3, dir: 1'b0, seq: 4'b0011, lat: 5};
    send0(4'h3, 1'b0, e, 1'b1, c1);
    wait_idle0();

`ifdef SERIAL_FEEDER_STALL_EN
    // Stall three cycles after the first bit: word_done 3 cycles late
    e = '{word: 4'b1100, dir: 1'b0, seq: 4'b1100, lat: 8};
    send0(4'b1100, 1'b0, e, 1'b1, c1);
    @(posedge clk); #1 stall0 = 1'b1;
    repeat (3) @(posedge clk);
    #1 stall0 = 1'b0;
    wait_idle0();
`endif

    // dut2 (IDLE_GAP=2): in_valid held high, words A then 5, spacing 8
    exp2_q.push_back('{word: 4'hA, dir: 1'b0, seq: 4'b1010, lat: 5});
    exp2_q.push_back('{word: 4'h5, dir: 1'b1, seq: 4'b1010, lat: 5});
    h1 = -1;
    h2 = -1;
    if2.in_valid = 1'b1; if2.in_data = 4'hA; if2.in_dir = 1'b0;
    for (int k = 0; k < 40 && h2 < 0; k++) begin
      @(negedge clk);
      if (if2.in_ready) begin
        if (h1 < 0) begin
          h1 = cyc;
          @(posedge clk);
          #1 if2.in_data = 4'h5; if2.in_dir = 1'b1;
        end else begin
          h2 = cyc;
          @(posedge clk);
          #1 if2.in_valid = 1'b0;
        end
      end
    end
    check("gap_spacing", h2 - h1, 32'd8);
    for (int k = 0; k < 40 && exp2_q.size() > 0; k++) @(negedge clk);
    check("drain2", exp2_q.size(), 32'd0);

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
